// File: rtl/tt_um_i2c_master_top.sv
// Single-transaction I2C master (START, address+R/W, one data byte, STOP) driving an
// internal open-drain bus shared with a one-register I2C slave model.
module tt_um_i2c_master_top #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MASTER_NACK, STOP, DONE
    } state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_IGNORE
    } sl_state_t;

    state_t        state_reg, state_next;
    sl_state_t     sl_state_reg, sl_state_next;

    logic [DW-1:0] div_reg;
    logic [1:0]    q_reg;
    logic [2:0]    bit_reg;
    logic [6:0]    addr_reg;
    logic [7:0]    data_reg, rx_reg, uo_reg, addr_byte;
    logic          samp_reg, nack_reg, ready_reg;
    logic          scl_m, sda_m, scl_bus, sda_bus;
    logic          tick, bit_end, start_req;

    logic          scl_d_reg, sda_d_reg, sda_s_reg;
    logic [3:0]    sl_cnt_reg;
    logic [7:0]    sl_sh_reg, sl_tx_reg, sl_mem_reg;
    logic          scl_rise, scl_fall, start_cond, stop_cond;

    assign tick      = (div_reg == DW'(CLK_DIV - 1));
    assign bit_end   = tick && (q_reg == 2'd3);
    assign start_req = ena && ui_in[7];
    assign addr_byte = {addr_reg, data_reg[7]};

    assign scl_bus = scl_m;
    assign sda_bus = sda_m & sda_s_reg;

    assign uo_out  = uo_reg;
    assign uio_out = {4'b0000, sda_bus, scl_bus, ready_reg, nack_reg};
    assign uio_oe  = 8'b0000_1111;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:        if (start_req) state_next = START;
            START:       if (bit_end) state_next = ADDR;
            ADDR:        if (bit_end && bit_reg == 3'd7) state_next = ADDR_ACK;
            ADDR_ACK:    if (bit_end) state_next = samp_reg ? STOP : (data_reg[7] ? READ : WRITE);
            WRITE:       if (bit_end && bit_reg == 3'd7) state_next = WRITE_ACK;
            WRITE_ACK:   if (bit_end) state_next = STOP;
            READ:        if (bit_end && bit_reg == 3'd7) state_next = MASTER_NACK;
            MASTER_NACK: if (bit_end) state_next = STOP;
            STOP:        if (bit_end) state_next = DONE;
            default:     state_next = IDLE;
        endcase
    end

    // Quarter phases per bit: 0 SCL low/setup, 1 rise, 2 high/sample, 3 fall.
    always_comb begin
        scl_m = 1'b1;
        sda_m = 1'b1;
        case (state_reg)
            START: begin
                scl_m = (q_reg != 2'd3);
                sda_m = (q_reg == 2'd0);
            end
            ADDR: begin
                scl_m = q_reg[0] ^ q_reg[1];
                sda_m = addr_byte[~bit_reg];
            end
            WRITE: begin
                scl_m = q_reg[0] ^ q_reg[1];
                sda_m = data_reg[~bit_reg];
            end
            ADDR_ACK, WRITE_ACK, READ, MASTER_NACK: scl_m = q_reg[0] ^ q_reg[1];
            STOP: begin
                scl_m = (q_reg != 2'd0);
                sda_m = q_reg[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_reg <= '0;
            q_reg   <= 2'd0;
            bit_reg <= 3'd0;
        end else if (state_reg == IDLE || state_reg == DONE) begin
            div_reg <= '0;
            q_reg   <= 2'd0;
            bit_reg <= 3'd0;
        end else begin
            div_reg <= tick ? '0 : div_reg + DW'(1);
            if (tick) q_reg <= q_reg + 2'd1;
            if (bit_end) bit_reg <= (state_next != state_reg) ? 3'd0 : bit_reg + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            addr_reg  <= 7'd0;
            data_reg  <= 8'd0;
            rx_reg    <= 8'd0;
            uo_reg    <= 8'd0;
            samp_reg  <= 1'b1;
            nack_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            ready_reg <= (state_next == IDLE);
            if (state_reg == IDLE && start_req) begin
                addr_reg <= ui_in[6:0];
                data_reg <= uio_in;
                nack_reg <= 1'b0;
            end
            if (tick && q_reg == 2'd2) begin
                samp_reg <= sda_bus;
                if (state_reg == READ) rx_reg <= {rx_reg[6:0], sda_bus};
            end
            if (bit_end && samp_reg && (state_reg == ADDR_ACK || state_reg == WRITE_ACK))
                nack_reg <= 1'b1;
            if (bit_end && state_reg == MASTER_NACK) uo_reg <= rx_reg;
        end
    end

    // Slave model: samples on SCL rise, changes its SDA drive only after SCL falls.
    assign scl_rise   = scl_bus & ~scl_d_reg;
    assign scl_fall   = ~scl_bus & scl_d_reg;
    assign start_cond = scl_bus & scl_d_reg & sda_d_reg & ~sda_bus;
    assign stop_cond  = scl_bus & scl_d_reg & ~sda_d_reg & sda_bus;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) sl_state_reg <= S_IDLE;
        else       sl_state_reg <= sl_state_next;
    end

    always_comb begin
        sl_state_next = sl_state_reg;
        if (start_cond)     sl_state_next = S_ADDR;
        else if (stop_cond) sl_state_next = S_IDLE;
        else if (scl_fall) begin
            case (sl_state_reg)
                S_ADDR:  if (sl_cnt_reg == 4'd8)
                             sl_state_next = (sl_sh_reg[7:1] == SLAVE_ADDR) ? S_AACK : S_IGNORE;
                S_AACK:  sl_state_next = sl_sh_reg[0] ? S_READ : S_WRITE;
                S_WRITE: if (sl_cnt_reg == 4'd8) sl_state_next = S_WACK;
                S_WACK:  sl_state_next = S_IGNORE;
                S_READ:  if (sl_cnt_reg == 4'd8) sl_state_next = S_IGNORE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            scl_d_reg  <= 1'b1;
            sda_d_reg  <= 1'b1;
            sda_s_reg  <= 1'b1;
            sl_cnt_reg <= 4'd0;
            sl_sh_reg  <= 8'd0;
            sl_tx_reg  <= 8'd0;
            sl_mem_reg <= 8'd0;
        end else begin
            scl_d_reg <= scl_bus;
            sda_d_reg <= sda_bus;
            if (sl_state_next != sl_state_reg) sl_cnt_reg <= 4'd0;
            else if (scl_rise)                 sl_cnt_reg <= sl_cnt_reg + 4'd1;
            if (scl_rise && (sl_state_reg == S_ADDR || sl_state_reg == S_WRITE))
                sl_sh_reg <= {sl_sh_reg[6:0], sda_bus};
            if (sl_state_reg == S_WRITE && sl_state_next == S_WACK)
                sl_mem_reg <= sl_sh_reg;
            if (start_cond || stop_cond) sda_s_reg <= 1'b1;
            else if (scl_fall) begin
                case (sl_state_next)
                    S_AACK, S_WACK: sda_s_reg <= 1'b0;
                    S_READ: begin
                        if (sl_state_reg == S_AACK) begin
                            sda_s_reg <= sl_mem_reg[7];
                            sl_tx_reg <= {sl_mem_reg[6:0], 1'b0};
                        end else begin
                            sda_s_reg <= sl_tx_reg[7];
                            sl_tx_reg <= {sl_tx_reg[6:0], 1'b0};
                        end
                    end
                    default: sda_s_reg <= 1'b1;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tt_um_i2c_master_top.sv
// Randomized scoreboard bench: the stimulus pushes the expected bus bit stream, result
// byte, nack flag and busy length; a monitor decodes the bus and compares on completion.
module tb_tt_um_i2c_master_top;
    localparam int         CLK_DIV  = 4;
    localparam logic [6:0] SLAVE    = 7'h2A;
    localparam int         BIT_CLKS = 4 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_i2c_master_top #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(SLAVE)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    logic nack, ready, scl, sda;
    assign nack  = uio_out[0];
    assign ready = uio_out[1];
    assign scl   = uio_out[2];
    assign sda   = uio_out[3];

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        logic [7:0]  uo;
        logic        nk;
        int          len;
        logic [31:0] bits;
        int          nbits;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] m_reg = 8'h00;
    logic [7:0] m_uo = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: which bits appear on SDA at each SCL rise, plus the final result.
    task automatic push_expect(input logic [6:0] a, input logic [7:0] d);
        exp_t       e;
        logic [7:0] ab;
        logic [7:0] payload;
        ab = {a, d[7]};
        e.a = a; e.d = d; e.bits = 0; e.nbits = 0;
        for (int i = 7; i >= 0; i--) begin e.bits = {e.bits[30:0], ab[i]}; e.nbits++; end
        if (a != SLAVE) begin
            e.bits = {e.bits[30:0], 1'b1}; e.nbits++;
            e.nk = 1'b1;
            e.len = 11 * BIT_CLKS + 1;
        end else begin
            e.bits = {e.bits[30:0], 1'b0}; e.nbits++;
            payload = d[7] ? m_reg : d;
            for (int i = 7; i >= 0; i--) begin e.bits = {e.bits[30:0], payload[i]}; e.nbits++; end
            e.bits = {e.bits[30:0], d[7]}; e.nbits++;
            if (d[7]) m_uo = m_reg;
            else      m_reg = d;
            e.nk = 1'b0;
            e.len = 20 * BIT_CLKS + 1;
        end
        e.bits = {e.bits[30:0], 1'b0}; e.nbits++;
        e.uo = m_uo;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        bit          active;
        int          cyc, gn, starts, stops;
        logic [31:0] gbits;
        logic        pscl, psda;
        active = 0; cyc = 0; gn = 0; starts = 0; stops = 0; gbits = 0;
        pscl = 1'b1; psda = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n) active = 0;
            else if (!ready) begin
                if (!active) begin
                    active = 1; cyc = 0; gbits = 0; gn = 0; starts = 0; stops = 0;
                end
                cyc++;
                if (scl && !pscl) begin gbits = {gbits[30:0], sda}; gn++; end
                if (scl && pscl && psda && !sda) starts++;
                if (scl && pscl && !psda && sda) stops++;
            end else if (active) begin
                active = 0;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_txn got=one want=none");
                end else begin
                    e = exp_q.pop_front();
                    check("bus_bits", gbits, e.bits);
                    check("bus_nbits", gn, e.nbits);
                    check("uo_out", uo_out, e.uo);
                    check("nack", nack, e.nk);
                    check("busy_cycles", cyc, e.len);
                    check("start_count", starts, 1);
                    check("stop_count", stops, 1);
                    $display("txn addr=%h data=%h uo=%h nack=%b cycles=%0d", e.a, e.d, uo_out, nack, cyc);
                end
            end
            pscl = scl;
            psda = sda;
        end
    end

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!ready && n < budget) begin @(negedge clk); n++; end
        if (!ready) begin
            total++; bad++;
            $display("FAIL ready_timeout got=0 want=1");
        end
    endtask

    task automatic do_txn(input logic [6:0] a, input logic [7:0] d, input bit poke);
        wait_ready(2000);
        @(negedge clk);
        ui_in = {1'b1, a};
        uio_in = d;
        push_expect(a, d);
        @(negedge clk);
        ui_in[7] = 1'b0;
        check("ready_fall", ready, 0);
        if (poke) begin
            repeat (40) @(negedge clk);
            ui_in = {1'b1, SLAVE};
            uio_in = ~d;
            @(negedge clk);
            ui_in[7] = 1'b0;
        end
        @(negedge clk);
        wait_ready(2000);
    endtask

    task automatic release_reset();
        @(negedge clk);
        #4 rst_n = 1'b0;
        @(negedge clk);
        check("ready_after_release", ready, 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit          ok;
        logic [6:0]  a;
        logic [7:0]  d;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_uo", uo_out, 8'h00);
        check("rst_nack", nack, 0);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("uio_oe", uio_oe, 8'h0F);
        release_reset();

        do_txn(SLAVE, 8'h55, 0);
        do_txn(SLAVE, 8'h80, 0);
        do_txn(7'h55, 8'hAA, 0);
        do_txn(SLAVE, 8'h80, 0);

        ena = 1'b0;
        ui_in = {1'b1, SLAVE};
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (!ready || !scl || !sda) ok = 0;
        end
        check("ena_low_idle", ok, 1);
        ui_in = 8'h00;
        @(negedge clk);
        ena = 1'b1;

        do_txn(SLAVE, 8'h3C, 1);
        do_txn(SLAVE, 8'h81, 1);

        for (int i = 0; i < 10; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLAVE;
            d = 8'($urandom);
            do_txn(a, d, bit'($urandom_range(0, 1)));
        end

        wait_ready(2000);
        @(negedge clk);
        ui_in = {1'b1, SLAVE};
        uio_in = 8'h5A;
        push_expect(SLAVE, 8'h5A);
        @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b1;
        exp_q.delete();
        m_reg = 8'h00;
        m_uo = 8'h00;
        #1;
        check("abort_ready", ready, 0);
        check("abort_uo", uo_out, 8'h00);
        check("abort_nack", nack, 0);
        check("abort_scl", scl, 1);
        check("abort_sda", sda, 1);
        release_reset();

        do_txn(SLAVE, 8'hA3, 0);
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tt_um_i2c_master_top.md
Name: tt_um_i2c_master_top

Overview:
Single-transaction I2C master with an integrated on-chip I2C slave model, in TinyTapeout top-level pinout. A host sets a 7-bit address on ui_in and a data/RW byte on uio_in, then pulses ui_in[7]. The block runs START, address+R/W, one data byte and STOP on an internal open-drain SCL/SDA bus. Read data appears on uo_out, and completion is flagged by ready.

Parameters:
CLK_DIV, 4, system clocks per SCL quarter-period (one bit = 4*CLK_DIV clocks; must be >=1)
SLAVE_ADDR, 7'h2A, address the internal slave responds to

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset; asynchronous, active-high (asserted when 1) despite the name
ena  input  1  design select; when 0, start requests are ignored (a running transaction completes)
ui_in  input  8  [6:0] slave address, [7] start request (level, sampled in IDLE)
uio_in  input  8  write data byte; bit [7] also selects direction (1=read, 0=write)
uo_out  output  8  last read data byte
uio_out  output  8  [0] nack flag, [1] ready, [2] SCL, [3] SDA (bus observation), [7:4]=0
uio_oe  output  8  constant 8'b0000_1111

Behaviour:
- Reset (rst_n=1): state=IDLE, uo_out=0, ready=0, nack=0, SCL=SDA=1, slave register=8'h00, slave state idle. ready is registered and goes 1 on the first clk edge after reset deasserts.
- ready=1 only in IDLE; otherwise 0.
- IDLE: if ena=1 and ui_in[7]=1 on a rising edge, latch addr=ui_in[6:0], byte=uio_in, rw=uio_in[7]. Clear nack, go START; ready=0 from the next edge. A one-cycle pulse is sufficient. ui_in[7] held high restarts a new transaction immediately after completion.
- Bit timing: quarter-period tick every CLK_DIV clocks; each bit has 4 phases (SCL low/SDA setup, SCL rise, SCL high/sample, SCL fall).
- States and bus sequence:
  - START: SDA falls while SCL=1.
  - ADDR: 8 bits {addr, rw}, MSB first.
  - ADDR_ACK: master releases SDA and samples at SCL high. ACK=0 goes to WRITE or READ by rw. NACK=1 sets nack and goes STOP.
  - WRITE: 8 bits of latched byte, MSB first.
  - WRITE_ACK: sample; a NACK sets nack.
  - READ: master releases SDA, samples 8 bits MSB first into a shift register.
  - MASTER_NACK: master drives SDA=1 for one bit.
  - STOP: SDA rises while SCL=1.
  - DONE: one cycle, then IDLE.
- Bus: wired-AND of master and slave SDA drivers; SCL driven only by master.
- Slave model:
  - Detects START/STOP.
  - Shifts in 8 address bits; ACKs (drives 0) only if bits[7:1]==SLAVE_ADDR.
  - Write: stores the received byte into its register and ACKs it.
  - Read: shifts out its register MSB first.
  - Mismatched address: stays silent until STOP.
- uo_out updated with the shift register only on completion of a successful read (on STOP entry); unchanged on write or NACK.
- Transaction length with no NACK is exactly 20 bit times + DONE. With address NACK it is 11 bit times (START, 9 addr bits, STOP).
- Start requests during a transaction are ignored.
- Reset mid-transaction aborts immediately to reset values, including slave register=0.

Test Plan:
- Reset, then release: ready 0 during reset, 1 within one clock after release; uo_out=0x00, nack=0, SCL=SDA=1.
- Write: addr 0x2A, uio_in=0x55, one-cycle ui_in[7] pulse. Expect ready falls next edge; bus shows START, byte 0x54 (0x2A<<1|0), ACK, 0x55, ACK, STOP; ready returns after 20*4*CLK_DIV+~2 clocks; nack=0; slave register=0x55.
- Read: addr 0x2A, uio_in=0x80 (rw=1). Expect address byte 0x55 ACKed, uo_out=0x55 at completion, nack=0, master NACK bit SDA=1.
- Bad address: addr 0x55, uio_in=0xAA. Expect address NACK, nack=1, STOP after 9th bit, uo_out still 0x55, slave register unchanged.
- ena=0 with ui_in[7]=1: ready stays 1, bus idle. Start pulse while busy: ignored, transaction length unchanged.
- Assert rst_n mid-write: outputs return to reset values asynchronously; after release a new write of 0xA3 (rw=1 → read instead) behaves per spec with register=0x00 returned.
